// File: rtl/mand_solver_stream.sv
// ============================================================================
// Module   : mand_solver_stream (with helper signed_mult)
// Purpose  : Escape-time solver for z <= z^2 + c, one iteration per clock,
//            with valid/ready handshakes, Mandelbrot/Julia modes and a tag.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module signed_mult #(
    parameter int INT_BITS  = 4,
    parameter int FRAC_BITS = 23,
    localparam int W        = INT_BITS + FRAC_BITS
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] p
);
    logic signed [2*W-1:0] ax;
    logic signed [2*W-1:0] bx;

    assign ax = {{W{a[W-1]}}, a};
    assign bx = {{W{b[W-1]}}, b};
    // Fixed-point product: drop FRAC_BITS fraction bits, keep W bits (wraps).
    assign p  = W'((ax * bx) >>> FRAC_BITS);
endmodule

module mand_solver_stream #(
    parameter int INT_BITS   = 4,
    parameter int FRAC_BITS  = 23,
    parameter int ITER_W     = 16,
    parameter int TAG_W      = 20,
    parameter logic [INT_BITS+FRAC_BITS:0] ESCAPE_MAG =
        (INT_BITS+FRAC_BITS+1)'(4 << FRAC_BITS)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           in_mode,
    input  logic [INT_BITS+FRAC_BITS-1:0]  in_c_re,
    input  logic [INT_BITS+FRAC_BITS-1:0]  in_c_im,
    input  logic [INT_BITS+FRAC_BITS-1:0]  in_z0_re,
    input  logic [INT_BITS+FRAC_BITS-1:0]  in_z0_im,
    input  logic [ITER_W-1:0]              in_max_iter,
    input  logic [TAG_W-1:0]               in_tag,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [ITER_W-1:0]              out_iter,
    output logic                           out_escaped,
    output logic [TAG_W-1:0]               out_tag
);
    localparam int W          = INT_BITS + FRAC_BITS;
    localparam int GUARD_BITS = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic signed [W-1:0] z_re;
    logic signed [W-1:0] z_im;
    logic signed [W-1:0] c_re;
    logic signed [W-1:0] c_im;
    logic [ITER_W-1:0]   iter;
    logic [ITER_W-1:0]   max_iter;

    logic signed [W-1:0] re2;
    logic signed [W-1:0] im2;
    logic signed [W-1:0] reim;
    logic [W:0]          mag;
    logic                guard_re_ok;
    logic                guard_im_ok;
    logic                escape;
    logic                at_limit;
    logic [W-1:0]        next_re;
    logic [W-1:0]        next_im;

    signed_mult #(.INT_BITS(INT_BITS), .FRAC_BITS(FRAC_BITS)) u_mult_re2 (
        .a(z_re), .b(z_re), .p(re2)
    );
    signed_mult #(.INT_BITS(INT_BITS), .FRAC_BITS(FRAC_BITS)) u_mult_im2 (
        .a(z_im), .b(z_im), .p(im2)
    );
    signed_mult #(.INT_BITS(INT_BITS), .FRAC_BITS(FRAC_BITS)) u_mult_reim (
        .a(z_re), .b(z_im), .p(reim)
    );

    // Each component must stay within [-4,4) so its square is exact as an
    // unsigned W-bit value on the magnitude path; a wrapped sum lands outside.
    assign guard_re_ok = (z_re[W-1 -: GUARD_BITS] == {GUARD_BITS{z_re[W-1]}});
    assign guard_im_ok = (z_im[W-1 -: GUARD_BITS] == {GUARD_BITS{z_im[W-1]}});

    assign mag      = {1'b0, re2} + {1'b0, im2};
    assign escape   = (mag > ESCAPE_MAG) || !guard_re_ok || !guard_im_ok;
    assign at_limit = (iter == max_iter);
    assign next_re  = re2 - im2 + c_re;
    assign next_im  = (reim <<< 1) + c_im;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid)            next_state = ITER;
            ITER:    if (escape || at_limit)  next_state = DONE;
            DONE:    if (out_ready)           next_state = IDLE;
            default:                          next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            z_re        <= '0;
            z_im        <= '0;
            c_re        <= '0;
            c_im        <= '0;
            iter        <= '0;
            max_iter    <= '0;
            out_iter    <= '0;
            out_escaped <= 1'b0;
            out_tag     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        c_re     <= in_c_re;
                        c_im     <= in_c_im;
                        z_re     <= in_mode ? in_z0_re : in_c_re;
                        z_im     <= in_mode ? in_z0_im : in_c_im;
                        max_iter <= in_max_iter;
                        out_tag  <= in_tag;
                        iter     <= '0;
                    end
                end
                ITER: begin
                    if (escape) begin
                        out_iter    <= iter;
                        out_escaped <= 1'b1;
                    end else if (at_limit) begin
                        out_iter    <= iter;
                        out_escaped <= 1'b0;
                    end else begin
                        z_re <= next_re;
                        z_im <= next_im;
                        iter <= iter + ITER_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_mand_solver_stream.sv
// ============================================================================
// Module   : tb_mand_solver_stream
// Purpose  : Directed self-checking bench for mand_solver_stream.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mand_solver_stream;
    localparam int W = 27;

    localparam logic [W-1:0] ZERO    = 27'h0000000;
    localparam logic [W-1:0] HALF    = 27'h0400000;
    localparam logic [W-1:0] ONE     = 27'h0800000;
    localparam logic [W-1:0] THREE   = 27'h1800000;
    localparam logic [W-1:0] NEG_TWO = 27'h7000000;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_mode = 1'b0;
    logic [W-1:0]  in_c_re = '0;
    logic [W-1:0]  in_c_im = '0;
    logic [W-1:0]  in_z0_re = '0;
    logic [W-1:0]  in_z0_im = '0;
    logic [15:0]   in_max_iter = '0;
    logic [19:0]   in_tag = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [15:0]   out_iter;
    logic          out_escaped;
    logic [19:0]   out_tag;

    int pass_cnt = 0;
    int total    = 0;
    int cyc      = 0;
    int last_accept = 0;

    mand_solver_stream dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mode    (in_mode),
        .in_c_re    (in_c_re),
        .in_c_im    (in_c_im),
        .in_z0_re   (in_z0_re),
        .in_z0_im   (in_z0_im),
        .in_max_iter(in_max_iter),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_iter   (out_iter),
        .out_escaped(out_escaped),
        .out_tag    (out_tag)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Offer one point; the solver is idle so it is taken on the next edge.
    task automatic send(input logic mode, input logic [W-1:0] cre, input logic [W-1:0] cim,
                        input logic [W-1:0] zre, input logic [W-1:0] zim,
                        input logic [15:0] mi, input logic [19:0] tag);
        @(negedge clock);
        in_mode = mode; in_c_re = cre; in_c_im = cim;
        in_z0_re = zre; in_z0_im = zim; in_max_iter = mi; in_tag = tag;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        last_accept = cyc;
        in_valid = 1'b0;
        in_c_re = '0; in_c_im = '0; in_z0_re = '0; in_z0_im = '0; in_tag = '0;
    endtask

    task automatic wait_result(output int cycles, output bit timed_out);
        cycles = 0;
        timed_out = 1'b0;
        while (!out_valid) begin
            @(posedge clock);
            #1;
            cycles++;
            if (cycles > 3000) begin
                timed_out = 1'b1;
                break;
            end
        end
    endtask

    task automatic take();
        @(negedge clock);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else pass_cnt++;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else pass_cnt++;
        total++; if (out_iter !== 16'd0) $display("FAIL reset_out_iter got=%0d exp=0", out_iter); else pass_cnt++;
        total++; if (out_escaped !== 1'b0) $display("FAIL reset_out_escaped got=%b exp=0", out_escaped); else pass_cnt++;
        total++; if (out_tag !== 20'd0) $display("FAIL reset_out_tag got=%h exp=0", out_tag); else pass_cnt++;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_mandel_origin();
        int n; bit to;
        send(1'b0, ZERO, ZERO, ZERO, ZERO, 16'd100, 20'h00001);
        wait_result(n, to);
        total++; if (to) $display("FAIL origin_timeout got=timeout exp=result"); else pass_cnt++;
        total++; if (out_iter !== 16'd100) $display("FAIL origin_iter got=%0d exp=100", out_iter); else pass_cnt++;
        total++; if (out_escaped !== 1'b0) $display("FAIL origin_escaped got=%b exp=0", out_escaped); else pass_cnt++;
        total++; if (n != 101) $display("FAIL origin_latency got=%0d exp=101", n); else pass_cnt++;
        take();
    endtask

    task automatic test_mandel_one();
        int n; bit to;
        send(1'b0, ONE, ZERO, ZERO, ZERO, 16'd100, 20'h00002);
        wait_result(n, to);
        total++; if (out_iter !== 16'd2) $display("FAIL one_iter got=%0d exp=2", out_iter); else pass_cnt++;
        total++; if (out_escaped !== 1'b1) $display("FAIL one_escaped got=%b exp=1", out_escaped); else pass_cnt++;
        total++; if (n != 3 || to) $display("FAIL one_latency got=%0d exp=3", n); else pass_cnt++;
        take();
    endtask

    task automatic test_mandel_minus2();
        int n; bit to;
        send(1'b0, NEG_TWO, ZERO, ZERO, ZERO, 16'd50, 20'h00003);
        wait_result(n, to);
        total++; if (out_iter !== 16'd50) $display("FAIL minus2_iter got=%0d exp=50", out_iter); else pass_cnt++;
        total++; if (out_escaped !== 1'b0 || to) $display("FAIL minus2_escaped got=%b exp=0", out_escaped); else pass_cnt++;
        take();
    endtask

    // c=0.5: z = .5, .75, 1.0625, 1.6289, 3.15 -> magnitude escape at iter 4
    task automatic test_mandel_half();
        int n; bit to;
        send(1'b0, HALF, ZERO, ZERO, ZERO, 16'd100, 20'h00004);
        wait_result(n, to);
        total++; if (out_iter !== 16'd4) $display("FAIL half_iter got=%0d exp=4", out_iter); else pass_cnt++;
        total++; if (out_escaped !== 1'b1 || to) $display("FAIL half_escaped got=%b exp=1", out_escaped); else pass_cnt++;
        take();
    endtask

    // c=i cycles i -> -1+i -> -i -> -1+i ...; exercises the imaginary path
    task automatic test_mandel_imag();
        int n; bit to;
        send(1'b0, ZERO, ONE, ZERO, ZERO, 16'd20, 20'hABCDE);
        wait_result(n, to);
        total++; if (out_iter !== 16'd20) $display("FAIL imag_iter got=%0d exp=20", out_iter); else pass_cnt++;
        total++; if (out_escaped !== 1'b0 || to) $display("FAIL imag_escaped got=%b exp=0", out_escaped); else pass_cnt++;
        total++; if (out_tag !== 20'hABCDE) $display("FAIL imag_tag got=%h exp=abcde", out_tag); else pass_cnt++;
        take();
    endtask

    task automatic test_julia();
        int n; bit to;
        send(1'b1, ZERO, ZERO, THREE, ZERO, 16'd10, 20'h00005);
        wait_result(n, to);
        total++; if (out_iter !== 16'd0) $display("FAIL julia3_iter got=%0d exp=0", out_iter); else pass_cnt++;
        total++; if (out_escaped !== 1'b1 || to) $display("FAIL julia3_escaped got=%b exp=1", out_escaped); else pass_cnt++;
        take();
        send(1'b1, ZERO, ZERO, HALF, ZERO, 16'd0, 20'h00006);
        wait_result(n, to);
        total++; if (out_iter !== 16'd0) $display("FAIL julia_max0_iter got=%0d exp=0", out_iter); else pass_cnt++;
        total++; if (out_escaped !== 1'b0 || to) $display("FAIL julia_max0_escaped got=%b exp=0", out_escaped); else pass_cnt++;
        total++; if (n != 1) $display("FAIL julia_max0_latency got=%0d exp=1", n); else pass_cnt++;
        take();
    endtask

    task automatic test_backpressure();
        int n; bit to; bit stable;
        send(1'b0, ZERO, ZERO, ZERO, ZERO, 16'd3, 20'h12345);
        wait_result(n, to);
        total++; if (out_iter !== 16'd3 || to) $display("FAIL bp_iter got=%0d exp=3", out_iter); else pass_cnt++;
        total++; if (out_tag !== 20'h12345) $display("FAIL bp_tag got=%h exp=12345", out_tag); else pass_cnt++;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (out_valid !== 1'b1 || out_iter !== 16'd3 || out_escaped !== 1'b0 ||
                out_tag !== 20'h12345 || in_ready !== 1'b0)
                stable = 1'b0;
        end
        total++; if (!stable) $display("FAIL bp_hold_stable got=changed exp=stable"); else pass_cnt++;
        take();
        total++; if (out_valid !== 1'b0) $display("FAIL bp_release_valid got=%b exp=0", out_valid); else pass_cnt++;
        total++; if (in_ready !== 1'b1) $display("FAIL bp_release_ready got=%b exp=1", in_ready); else pass_cnt++;
        @(posedge clock); #1;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL bp_single_handshake got=%b exp=0", out_valid); else pass_cnt++;
    endtask

    task automatic test_reset_abort();
        int n; bit to;
        send(1'b0, ZERO, ZERO, ZERO, ZERO, 16'd100, 20'h00007);
        repeat (5) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL abort_in_ready got=%b exp=1", in_ready); else pass_cnt++;
        total++; if (out_valid !== 1'b0) $display("FAIL abort_out_valid got=%b exp=0", out_valid); else pass_cnt++;
        @(negedge clock);
        reset = 1'b0;
        send(1'b0, ONE, ZERO, ZERO, ZERO, 16'd100, 20'h00008);
        wait_result(n, to);
        total++; if (out_iter !== 16'd2 || to) $display("FAIL abort_next_iter got=%0d exp=2", out_iter); else pass_cnt++;
        total++; if (out_escaped !== 1'b1) $display("FAIL abort_next_escaped got=%b exp=1", out_escaped); else pass_cnt++;
        total++; if (out_tag !== 20'h00008) $display("FAIL abort_next_tag got=%h exp=00008", out_tag); else pass_cnt++;
        take();
    endtask

    // K=2 point drained immediately; next accept lands K+3 edges later
    task automatic test_back_to_back();
        int n; bit to; int first_accept;
        send(1'b0, ONE, ZERO, ZERO, ZERO, 16'd100, 20'h00009);
        first_accept = last_accept;
        wait_result(n, to);
        take();
        send(1'b1, ZERO, ZERO, HALF, ZERO, 16'd5, 20'h0000A);
        total++; if (last_accept - first_accept != 5) $display("FAIL b2b_spacing got=%0d exp=5", last_accept - first_accept); else pass_cnt++;
        wait_result(n, to);
        // z0=0.5, c=0: .5, .25, .0625, ... stays inside until limit 5
        total++; if (out_iter !== 16'd5 || to) $display("FAIL b2b_iter got=%0d exp=5", out_iter); else pass_cnt++;
        total++; if (out_tag !== 20'h0000A) $display("FAIL b2b_tag got=%h exp=0000a", out_tag); else pass_cnt++;
        total++; if (n != 6) $display("FAIL b2b_latency got=%0d exp=6", n); else pass_cnt++;
        take();
    endtask

    initial begin
        test_reset();
        test_mandel_origin();
        test_mandel_one();
        test_mandel_minus2();
        test_mandel_half();
        test_mandel_imag();
        test_julia();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

`default_nettype wire
